// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer
//   Drives one floating-gate program operation per accepted command. The
//   operation selects a cell through the row and column decoders, lets the
//   lines settle, issues a train of injection or tunnelling pulses with idle
//   gaps between them, and then lets the lines recover before it reports done.
//
// Optional feature:
//   FG_PROG_ABORT_EN : when defined, adds the abort input. Asserting abort in
//                      SETUP, PULSE or GAP cuts the command short and goes
//                      straight to RECOVER.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake. A command transfers on a rising
//                         edge where cmd_valid and cmd_ready are both 1. All
//                         cmd_* fields are captured on that edge. cmd_ready is
//                         1 only while the sequencer is idle. cmd_valid can be
//                         held high while cmd_ready is 0.
//   cmd_row, cmd_col      target cell address
//   cmd_npulse            number of pulses (0 = select and recover only)
//   cmd_width             pulse width in cycles (0 is treated as 1)
//   cmd_tun               1 = tunnelling pulse (vtun_en), 0 = injection (pulse)
//   abort                 only with FG_PROG_ABORT_EN
//   dec_row, dec_col      decoder address. Holds the last address while idle.
//   dec_en, drain_sel     decoder enable and drain-select, on in SETUP/PULSE/GAP
//   prog_mode             1 for the whole command, including RECOVER
//   pulse, vtun_en        programming pulses. They are never both 1.
//   busy                  command in progress
//   done                  one-cycle strobe on the return to IDLE
//   pulses_done           pulses completed for the current or last command
// All outputs are flops, so glitch-free and cleared by the asynchronous reset.
module fg_prog_sequencer #(
  parameter int H_BITS     = 6,
  parameter int V_BITS     = 6,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [V_BITS-1:0] cmd_row,
  input  logic [H_BITS-1:0] cmd_col,
  input  logic [7:0]        cmd_npulse,
  input  logic [15:0]       cmd_width,
  input  logic              cmd_tun,
`ifdef FG_PROG_ABORT_EN
  input  logic              abort,
`endif
  output logic [V_BITS-1:0] dec_row,
  output logic [H_BITS-1:0] dec_col,
  output logic              dec_en,
  output logic              prog_mode,
  output logic              drain_sel,
  output logic              pulse,
  output logic              vtun_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pulses_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_RECOVER
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYC - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [V_BITS-1:0]   row_q, row_d;
  logic [H_BITS-1:0]   col_q, col_d;
  logic [7:0]          npulse_q, npulse_d;
  logic [15:0]         width_q, width_d;
  logic                tun_q, tun_d;
  logic [7:0]          pd_q, pd_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                dec_en_q, dec_en_d;
  logic                prog_mode_q, prog_mode_d;
  logic                pulse_q, pulse_d;
  logic                vtun_q, vtun_d;
  logic                done_q, done_d;
  logic                abort_w;
  logic [15:0]         width_load;

`ifdef FG_PROG_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // The counter counts down to zero. A width of 0 still gives a one-cycle pulse.
  assign width_load = (width_q == 16'd0) ? 16'd0 : width_q - 16'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    npulse_d = npulse_q;
    width_d  = width_q;
    tun_d    = tun_q;
    pd_d     = pd_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          row_d    = cmd_row;
          col_d    = cmd_col;
          npulse_d = cmd_npulse;
          width_d  = cmd_width;
          tun_d    = cmd_tun;
          pd_d     = 8'd0;
          cnt_d    = SETTLE_LOAD;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort_w) begin
          state_d = S_RECOVER;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == 16'd0) begin
          if (npulse_q != 8'd0) begin
            state_d = S_PULSE;
            cnt_d   = width_load;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (abort_w) begin
          // An interrupted pulse does not count.
          state_d = S_RECOVER;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == 16'd0) begin
          pd_d = (pd_q == 8'd255) ? pd_q : pd_q + 8'd1;
          // Compare at 9 bits so that pd_q = 255 cannot wrap.
          if (({1'b0, pd_q} + 9'd1) < {1'b0, npulse_q}) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (abort_w) begin
          state_d = S_RECOVER;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == 16'd0) begin
          state_d = S_PULSE;
          cnt_d   = width_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // The output flops are decoded from the next state, so they line up with state_q.
    cmd_ready_d = (state_d == S_IDLE);
    prog_mode_d = (state_d != S_IDLE);
    dec_en_d    = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_GAP);
    pulse_d     = (state_d == S_PULSE) && !tun_d;
    vtun_d      = (state_d == S_PULSE) && tun_d;
    done_d      = (state_q == S_RECOVER) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      npulse_q    <= '0;
      width_q     <= '0;
      tun_q       <= 1'b0;
      pd_q        <= '0;
      cmd_ready_q <= 1'b0;
      dec_en_q    <= 1'b0;
      prog_mode_q <= 1'b0;
      pulse_q     <= 1'b0;
      vtun_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      npulse_q    <= npulse_d;
      width_q     <= width_d;
      tun_q       <= tun_d;
      pd_q        <= pd_d;
      cmd_ready_q <= cmd_ready_d;
      dec_en_q    <= dec_en_d;
      prog_mode_q <= prog_mode_d;
      pulse_q     <= pulse_d;
      vtun_q      <= vtun_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign dec_row     = row_q;
  assign dec_col     = col_q;
  assign dec_en      = dec_en_q;
  assign drain_sel   = dec_en_q;
  assign prog_mode   = prog_mode_q;
  assign busy        = prog_mode_q;
  assign pulse       = pulse_q;
  assign vtun_en     = vtun_q;
  assign done        = done_q;
  assign pulses_done = pd_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Testbench for fg_prog_sequencer with the default parameters
// (SETTLE_CYC=4, GAP_CYC=2, H_BITS=V_BITS=6).
// Valid/ready: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both 1. The driver raises cmd_valid only while cmd_ready is 1.
// Each command pushes a record of hand-computed expected values. The monitor
// gathers per-command measurements and pops and compares the record on done.
module tb_fg_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [5:0] cmd_row = '0;
  logic [5:0] cmd_col = '0;
  logic [7:0] cmd_npulse = '0;
  logic [15:0] cmd_width = '0;
  logic       cmd_tun = 1'b0;
`ifdef FG_PROG_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [5:0] dec_row, dec_col;
  logic       dec_en, prog_mode, drain_sel, pulse, vtun_en, busy, done;
  logic [7:0] pulses_done;

  int checks = 0;
  int failures = 0;

  // Expected per-command result.
  typedef struct packed {
    logic [7:0]  pd;      // pulses_done at done
    logic [15:0] pcyc;    // cycles with pulse = 1
    logic [15:0] vcyc;    // cycles with vtun_en = 1
    logic [15:0] edges;   // rising edges of pulse or vtun_en
    logic [15:0] lat;     // busy cycles until done
    logic [15:0] first;   // busy cycles before the first pulse (0 = none)
    logic [5:0]  row;
    logic [5:0]  col;
  } exp_t;

  exp_t exp_q[$];

  fg_prog_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_npulse(cmd_npulse),
    .cmd_width(cmd_width), .cmd_tun(cmd_tun),
`ifdef FG_PROG_ABORT_EN
    .abort(abort),
`endif
    .dec_row(dec_row), .dec_col(dec_col), .dec_en(dec_en),
    .prog_mode(prog_mode), .drain_sel(drain_sel), .pulse(pulse),
    .vtun_en(vtun_en), .busy(busy), .done(done), .pulses_done(pulses_done)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor and scoreboard
  int   m_pcyc, m_vcyc, m_edges, m_lat, m_first;
  logic m_seen_first, m_overlap, m_prev_act;
  logic [5:0] m_row, m_col;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pcyc = 0; m_vcyc = 0; m_edges = 0; m_lat = 0; m_first = 0;
      m_seen_first = 1'b0; m_overlap = 1'b0; m_prev_act = 1'b0;
    end else begin
      if (pulse && vtun_en) m_overlap = 1'b1;
      if (busy) begin
        if ((pulse || vtun_en) && !m_seen_first) begin
          m_first = m_lat;
          m_seen_first = 1'b1;
        end
        if ((pulse || vtun_en) && !m_prev_act) m_edges++;
        if (pulse) m_pcyc++;
        if (vtun_en) m_vcyc++;
        if (dec_en) begin m_row = dec_row; m_col = dec_col; end
        m_lat++;
      end
      m_prev_act = pulse || vtun_en;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending command");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulses_done", int'(pulses_done), int'(e.pd));
          check("pulse_cycles", m_pcyc, int'(e.pcyc));
          check("vtun_cycles", m_vcyc, int'(e.vcyc));
          check("pulse_edges", m_edges, int'(e.edges));
          check("busy_to_done", m_lat, int'(e.lat));
          check("setup_cycles", m_first, int'(e.first));
          check("dec_row_active", int'(m_row), int'(e.row));
          check("dec_col_active", int'(m_col), int'(e.col));
          check("dec_row_idle_hold", int'(dec_row), int'(e.row));
          check("dec_col_idle_hold", int'(dec_col), int'(e.col));
          check("ready_at_done", int'(cmd_ready), 1);
          check("busy_at_done", int'(busy), 0);
          check("no_overlap", int'(m_overlap), 0);
        end
        m_pcyc = 0; m_vcyc = 0; m_edges = 0; m_lat = 0; m_first = 0;
        m_seen_first = 1'b0; m_overlap = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [5:0] row, input logic [5:0] col,
                      input int n, input int w, input logic tun, input logic push,
                      input int e_pd, input int e_pcyc, input int e_vcyc,
                      input int e_edges, input int e_lat, input int e_first);
    int budget;
    exp_t e;
    budget = 0;
    while (!cmd_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
      return;
    end
    if (push) begin
      e.pd = 8'(e_pd); e.pcyc = 16'(e_pcyc); e.vcyc = 16'(e_vcyc);
      e.edges = 16'(e_edges); e.lat = 16'(e_lat); e.first = 16'(e_first);
      e.row = row; e.col = col;
      exp_q.push_back(e);
    end
    cmd_row = row; cmd_col = col; cmd_npulse = 8'(n);
    cmd_width = 16'(w); cmd_tun = tun; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!done && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_done_timeout: got done=0 expected 1", name);
    end
  endtask

  // Stimulus
  initial begin
    int budget;
    #23;
    // Outputs while reset is held
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_outputs", int'({dec_en, prog_mode, drain_sel, pulse, vtun_en, busy, done}), 0);
    check("rst_dec_addr", int'({dec_row, dec_col}), 0);
    check("rst_pulses_done", int'(pulses_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", int'(cmd_ready), 1);

    // Basic inject train: 4 setup + 3*10 + 2*2 + 4 recover = 42 busy cycles
    send(6'd5, 6'd17, 3, 10, 1'b0, 1'b1, 3, 30, 0, 3, 42, 4);
    wait_done("basic");
    // npulse=0, accepted in the done cycle: 4 + 4 = 8 busy cycles
    send(6'd9, 6'd2, 0, 7, 1'b0, 1'b1, 0, 0, 0, 0, 8, 0);
    wait_done("npulse0");
    // Tunnel with width 0: 4 + 1 + 2 + 1 + 4 = 12
    send(6'd63, 6'd0, 2, 0, 1'b1, 1'b1, 2, 0, 2, 2, 12, 4);
    wait_done("width0_tun");
    // 255 pulses of width 1: 4 + 255 + 254*2 + 4 = 771
    send(6'd1, 6'd62, 255, 1, 1'b0, 1'b1, 255, 255, 0, 255, 771, 4);
    wait_done("npulse255");

`ifdef FG_PROG_ABORT_EN
    // Abort in the first cycle of the 2nd pulse: 4 + 10 + 2 + 1 + 4 = 21
    send(6'd3, 6'd3, 5, 10, 1'b0, 1'b1, 1, 11, 0, 2, 21, 4);
    begin
      int rises;
      logic prev;
      rises = 0; prev = 1'b0; budget = 0;
      while (rises < 2 && budget < 200) begin
        @(negedge clk);
        if (pulse && !prev) rises++;
        prev = pulse;
        budget++;
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_pulse_drop", int'(pulse), 0);
    check("abort_prog_mode", int'(prog_mode), 1);
    wait_done("abort");
`endif

    // Reset in the first GAP cycle. Nothing is pushed, so any done is flagged.
    send(6'd7, 6'd7, 3, 5, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    budget = 0;
    while (!pulse && budget < 100) begin @(negedge clk); budget++; end
    while (pulse && budget < 100) begin @(negedge clk); budget++; end
    check("in_gap_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midgap_rst_outputs", int'({dec_en, prog_mode, drain_sel, pulse, vtun_en, busy, done, cmd_ready}), 0);
    check("midgap_rst_pulses_done", int'(pulses_done), 0);
    check("midgap_rst_addr", int'({dec_row, dec_col}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_ready_low", int'(cmd_ready), 0);
    @(posedge clk);
    #1 check("release_ready_high", int'(cmd_ready), 1);
    repeat (20) @(negedge clk);

    // Operation after reset: tunnel, 1 pulse of 3 cycles, 4 + 3 + 4 = 11
    send(6'd10, 6'd20, 1, 3, 1'b1, 1'b1, 1, 0, 3, 1, 11, 4);
    wait_done("post_reset");
    repeat (5) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
